ecm24_wb_mem_cache: RTL
=======================

# ecm24_wb_mem_cache

Direct-mapped, write-through read cache on the SoC memory bus, between the SERV CPU memory Wishbone port and the SPI SRAM controller. It hides the SPI transfer latency for repeated instruction and data fetches. Read hits complete in one cycle without touching SPI. Misses and all writes are forwarded to the SPI SRAM controller.

## Interface
Parameters:
- DEPTH, 8: number of one-word lines; power of two, 2..64.
- ADR_W, 14: word-address width on the memory side (64 KB range).

Ports:
- wb_clk  in  1  single clock for the block.
- wb_rst  in  1  asynchronous, active-high reset.
- cpu_adr  in  32  byte address; bits [ADR_W+1:2] are used, the rest are ignored.
- cpu_dat  in  32  write data.
- cpu_sel  in  4  byte enables; used for writes only.
- cpu_we  in  1  write request.
- cpu_stb  in  1  request valid; held until cpu_ack.
- cpu_rdt  out  32  read data; valid while cpu_ack is high.
- cpu_ack  out  1  single-cycle completion pulse.
- mem_cyc  out  1  request to the SRAM controller; held until mem_ack.
- mem_adr  out  ADR_W  word address.
- mem_we  out  1  write request.
- mem_dat  out  32  write data.
- mem_sel  out  4  byte enables.
- mem_rdt  in  32  read data from the controller.
- mem_ack  in  1  controller completion pulse.
- inv  in  1  single-cycle pulse; invalidates all lines.

## Operation
- Address split: index = cpu_adr[2 +: log2(DEPTH)]; tag = cpu_adr[ADR_W+1 : 2+log2(DEPTH)].
- Per line: a valid bit, a tag and a 32-bit data word, all held in flops.
- Requests are sampled only in IDLE. No request is accepted in the cycle that cpu_ack is high.

State machine: IDLE, FILL, WRITE, ACK.
- IDLE, read hit (stb & !we & valid & tag match): register the line data into cpu_rdt, go to ACK.
- IDLE, read miss: go to FILL and assert mem_cyc with mem_we=0 and mem_sel=4'hF.
- FILL: on mem_ack, write mem_rdt into the line, set its tag and valid, register cpu_rdt=mem_rdt, go to ACK.
- IDLE, write: go to WRITE and assert mem_cyc with mem_we=1, passing cpu_dat and cpu_sel through.
- WRITE: on mem_ack, update the line only if it hits, merging the bytes enabled by sel. A write miss does not allocate. Go to ACK.
- ACK: cpu_ack=1 for one cycle, then IDLE.
- A write with sel=0 is still forwarded to memory and acked; the line is unchanged.
- mem_adr, mem_we, mem_dat and mem_sel are registered and stable for the whole of mem_cyc.
- inv, all states: every valid bit is cleared on the next edge.
- inv in the same cycle as a FILL mem_ack: the data is still returned to the CPU, but the line is left invalid (inv wins).
- Read data for a hit in the same cycle as inv: the hit is still served, because the lookup uses the pre-edge state.

## Timing
- Read hit: stb sampled at edge N; cpu_ack and cpu_rdt high in cycle N+1. Latency is 1.
- Miss or write: cpu_ack is asserted the cycle after mem_ack. Latency is controller latency + 2.
- mem_cyc rises the cycle after stb is sampled and falls the cycle after mem_ack.
- Reset values: state=IDLE, all valid=0, cpu_ack=0, cpu_rdt=0, mem_cyc=0, mem_we=0, mem_adr=0, mem_dat=0, mem_sel=0.
- Reset in mid-transaction: the block returns to IDLE immediately and mem_cyc drops. A mem_ack that arrives afterwards is ignored.

## Configuration
- ECM24_MEM_CACHE_STATS_EN defined: two extra outputs, hit_cnt[15:0] and miss_cnt[15:0].
  - Each increments once per read, when it leaves IDLE.
  - Both saturate at 16'hFFFF.
  - Both are cleared by reset only; inv does not clear them.
- ECM24_MEM_CACHE_STATS_EN not defined: the ports and counters do not exist. Cache behaviour is identical in both cases.

## Structure
- Package ecm24_cache_pkg holds:
  - the state enum (IDLE, FILL, WRITE, ACK);
  - a byte-merge function (old word, new word, sel) used on write hits;
  - the index and tag width helper functions derived from DEPTH and ADR_W.
- Sub-module ecm24_cache_line_store holds the valid, tag and data arrays. It has:
  - a combinational lookup port;
  - one write port (fill or merge);
  - a clear-all input driven by inv or reset.
- The top-level module contains the FSM, the memory-side registers and the optional counters.

## Test plan
- Cold read of 0x100 with the controller returning 0xDEADBEEF after 20 cycles: one mem_cyc, cpu_rdt=0xDEADBEEF, cpu_ack 1 cycle after mem_ack.
- Repeat read of 0x100: no mem_cyc; cpu_ack at N+1; cpu_rdt=0xDEADBEEF; with stats enabled, hit_cnt=1 and miss_cnt=1.
- Write 0x000000AA with sel=4'b0001 to 0x100, then read 0x100: memory write seen; read hits with 0xDEADBEAA.
- Write miss to 0x200, then read 0x200: the read misses (no allocate). Then read 0x120 (same index as 0x100 when DEPTH=8): eviction, so a subsequent read of 0x100 misses.
- inv pulsed in the same cycle as a FILL mem_ack: the CPU gets the data, and the next read of the same address misses.
- wb_rst asserted mid-FILL: mem_cyc=0 and cpu_ack=0 immediately. A late mem_ack produces no cpu_ack. The next read is a miss.

Source files
------------

// File: rtl/ecm24_cache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ecm24_cache_pkg
// Description : Shared types and helpers for the ecm24 memory-bus read cache:
//               FSM state encoding, index/tag width helpers, byte merge.
// Revision    : 1.0 - initial release
// ============================================================================
package ecm24_cache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_WRITE = 2'd2,
    ST_ACK   = 2'd3
  } state_t;

  // Number of word-address bits that select a cache line.
  function automatic int idx_width(input int depth);
    return $clog2(depth);
  endfunction

  // Remaining word-address bits stored as the line tag.
  function automatic int tag_width(input int depth, input int adr_w);
    return adr_w - $clog2(depth);
  endfunction

  // Replace the bytes of old_w selected by sel with those of new_w.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  sel);
    logic [31:0] res;
    res = old_w;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ecm24_cache_line_store.sv
`default_nettype none
// ============================================================================
// Module      : ecm24_cache_line_store
// Description : Valid/tag/data arrays of the direct-mapped cache. One
//               combinational lookup port, one write port (fill or merge)
//               and a clear-all input that drops every valid bit.
// Revision    : 1.0 - initial release
// ============================================================================
module ecm24_cache_line_store
  import ecm24_cache_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int ADR_W = 14,
  localparam int IDX_W = idx_width(DEPTH),
  localparam int TAG_W = tag_width(DEPTH, ADR_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [IDX_W-1:0] look_idx,
  input  logic [TAG_W-1:0] look_tag,
  output logic             look_hit,
  output logic [31:0]      look_data,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [31:0]      wr_data
);

  logic [DEPTH-1:0] valid;
  logic [TAG_W-1:0] tags [DEPTH];
  logic [31:0]      data [DEPTH];

  assign look_hit  = valid[look_idx] && (tags[look_idx] == look_tag);
  assign look_data = data[look_idx];

  // Valid bits: clear-all has priority so an invalidate racing a fill wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
    end else if (clr) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_idx] <= 1'b1;
    end
  end

  // Tag and data words are only meaningful behind a set valid bit.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tags[wr_idx] <= wr_tag;
      data[wr_idx] <= wr_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ecm24_wb_mem_cache.sv
`default_nettype none
// ============================================================================
// Module      : ecm24_wb_mem_cache
// Description : Direct-mapped, write-through, no-write-allocate read cache
//               between the CPU memory Wishbone port and the SPI SRAM
//               controller. Read hits ack in one cycle; misses and writes
//               go to the controller.
//               Optional macro ECM24_MEM_CACHE_STATS_EN adds saturating
//               hit_cnt/miss_cnt read counters.
// Revision    : 1.0 - initial release
// ============================================================================
module ecm24_wb_mem_cache
  import ecm24_cache_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int ADR_W = 14
) (
  input  logic             wb_clk,
  input  logic             wb_rst,
  input  logic [31:0]      cpu_adr,
  input  logic [31:0]      cpu_dat,
  input  logic [3:0]       cpu_sel,
  input  logic             cpu_we,
  input  logic             cpu_stb,
  output logic [31:0]      cpu_rdt,
  output logic             cpu_ack,
  output logic             mem_cyc,
  output logic [ADR_W-1:0] mem_adr,
  output logic             mem_we,
  output logic [31:0]      mem_dat,
  output logic [3:0]       mem_sel,
  input  logic [31:0]      mem_rdt,
  input  logic             mem_ack,
  input  logic             inv
`ifdef ECM24_MEM_CACHE_STATS_EN
  ,
  output logic [15:0]      hit_cnt,
  output logic [15:0]      miss_cnt
`endif
);

  localparam int IDX_W = idx_width(DEPTH);
  localparam int TAG_W = tag_width(DEPTH, ADR_W);

  state_t state, state_nxt;

  logic [ADR_W-1:0] req_adr;
  logic [ADR_W-1:0] look_adr;
  logic             hit;
  logic [31:0]      line_data;
  logic             accept;
  logic             fill_done;
  logic             write_hit_done;
  logic             wr_en;
  logic [31:0]      wr_data;

  // Byte offset and high address bits are outside the cached range.
  logic unused_adr_bits;
  assign unused_adr_bits = &{1'b0, cpu_adr[31:ADR_W+2], cpu_adr[1:0]};

  assign req_adr = cpu_adr[ADR_W+1:2];

  // In IDLE look up the incoming request; during a transfer look up the
  // latched address so a write can tell whether it hits.
  assign look_adr = (state == ST_IDLE) ? req_adr : mem_adr;

  assign accept         = (state == ST_IDLE) && cpu_stb;
  assign fill_done      = (state == ST_FILL) && mem_ack;
  assign write_hit_done = (state == ST_WRITE) && mem_ack && hit;
  assign wr_en          = fill_done || write_hit_done;
  assign wr_data        = fill_done ? mem_rdt : merge_bytes(line_data, mem_dat, mem_sel);

  ecm24_cache_line_store #(
    .DEPTH (DEPTH),
    .ADR_W (ADR_W)
  ) u_store (
    .clk       (wb_clk),
    .rst       (wb_rst),
    .clr       (inv),
    .look_idx  (look_adr[IDX_W-1:0]),
    .look_tag  (look_adr[ADR_W-1:IDX_W]),
    .look_hit  (hit),
    .look_data (line_data),
    .wr_en     (wr_en),
    .wr_idx    (mem_adr[IDX_W-1:0]),
    .wr_tag    (mem_adr[ADR_W-1:IDX_W]),
    .wr_data   (wr_data)
  );

  // State register; reset aborts any transfer in flight.
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt = state;
    cpu_ack   = 1'b0;
    mem_cyc   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cpu_stb) begin
          if (cpu_we)   state_nxt = ST_WRITE;
          else if (hit) state_nxt = ST_ACK;
          else          state_nxt = ST_FILL;
        end
      end
      ST_FILL, ST_WRITE: begin
        mem_cyc = 1'b1;
        if (mem_ack) state_nxt = ST_ACK;
      end
      ST_ACK: begin
        cpu_ack   = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Memory-side request registers and CPU read data.
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      cpu_rdt <= '0;
      mem_adr <= '0;
      mem_we  <= 1'b0;
      mem_dat <= '0;
      mem_sel <= '0;
    end else begin
      if (accept) begin
        mem_adr <= req_adr;
        mem_we  <= cpu_we;
        mem_dat <= cpu_dat;
        mem_sel <= cpu_we ? cpu_sel : 4'hF;
        if (!cpu_we && hit) cpu_rdt <= line_data;
      end
      if (fill_done) cpu_rdt <= mem_rdt;
    end
  end

`ifdef ECM24_MEM_CACHE_STATS_EN
  // Saturating read hit/miss counters, counted as a read leaves IDLE.
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (accept && !cpu_we) begin
      if (hit) begin
        if (hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
      end else begin
        if (miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
      end
    end
  end
`endif

endmodule
`default_nettype wire
